// File: rtl/adder_pipe_if.sv
// Operand/result handshake bundle for adder_pipe.
// The master side offers operands and consumes results. The slave side is the adder itself.
interface adder_pipe_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in1;
    logic [WIDTH-1:0] in2;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out;
    logic             carry;
    logic             overflow;

    modport master (
        output in_valid, in1, in2, sub, out_ready,
        input  in_ready, out_valid, out, carry, overflow
    );

    modport slave (
        input  in_valid, in1, in2, sub, out_ready,
        output in_ready, out_valid, out, carry, overflow
    );
endinterface

// File: rtl/adder_pipe.sv
// Carry-segmented pipelined adder/subtractor with valid/ready handshakes on both sides.
// Each stage adds one WIDTH/STAGES-bit chunk, starting with the LSB chunk. Every stage can stall on its own.
module adder_pipe #(
    parameter int WIDTH  = 32,
    parameter int STAGES = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    adder_pipe_if.slave  bus
);
    localparam int CW = WIDTH / STAGES;

    // Per-stage state. Only the chunks above k of r_a/r_b are still needed at stage k.
    logic [STAGES-1:0] r_valid;
    logic [STAGES-1:0] r_carry;
    logic [STAGES-1:0] r_sa;
    logic [STAGES-1:0] r_sb;
    logic [WIDTH-1:0]  r_sum [STAGES];
    logic [WIDTH-1:0]  r_a   [STAGES];
    logic [WIDTH-1:0]  r_b   [STAGES];
    logic              r_ovf;

    logic [STAGES-1:0] w_adv;
    logic [STAGES-1:0] w_v_nx;
    logic [STAGES-1:0] w_c_nx;
    logic [STAGES-1:0] w_sa_nx;
    logic [STAGES-1:0] w_sb_nx;
    logic [WIDTH-1:0]  w_sum_nx [STAGES];
    logic [WIDTH-1:0]  w_a_nx   [STAGES];
    logic [WIDTH-1:0]  w_b_nx   [STAGES];
    logic              w_ovf_nx;

    // Ready chain, walked from the output back to the input. It never looks at in_valid.
    always_comb begin
        logic adv;
        // NOTE: every always_comb output gets a default first. Otherwise a missed path infers a latch.
        w_adv = '0;
        adv   = !r_valid[STAGES-1] || bus.out_ready;
        w_adv[STAGES-1] = adv;
        for (int k = STAGES - 2; k >= 0; k--) begin
            adv      = !r_valid[k] || adv;
            w_adv[k] = adv;
        end
    end

    always_comb begin
        logic [CW:0]      chunk;
        logic             cin;
        logic [WIDTH-1:0] base;
        int               prev;
        w_v_nx  = '0;
        w_c_nx  = '0;
        w_sa_nx = '0;
        w_sb_nx = '0;
        chunk   = '0;
        cin     = 1'b0;
        base    = '0;
        prev    = 0;
        for (int k = 0; k < STAGES; k++) begin
            prev = (k == 0) ? 0 : k - 1;
            if (k == 0) begin
                w_a_nx[k]  = bus.in1;
                w_b_nx[k]  = bus.sub ? ~bus.in2 : bus.in2;
                cin        = bus.sub;
                base       = '0;
                w_v_nx[k]  = bus.in_valid;
                w_sa_nx[k] = bus.in1[WIDTH-1];
                w_sb_nx[k] = w_b_nx[k][WIDTH-1];
            end else begin
                w_a_nx[k]  = r_a[prev];
                w_b_nx[k]  = r_b[prev];
                cin        = r_carry[prev];
                base       = r_sum[prev];
                w_v_nx[k]  = r_valid[prev];
                w_sa_nx[k] = r_sa[prev];
                w_sb_nx[k] = r_sb[prev];
            end
            chunk = {1'b0, w_a_nx[k][k*CW +: CW]} + {1'b0, w_b_nx[k][k*CW +: CW]}
                  + {{CW{1'b0}}, cin};
            w_sum_nx[k]            = base;
            w_sum_nx[k][k*CW +: CW] = chunk[CW-1:0];
            w_c_nx[k]              = chunk[CW];
        end
        w_ovf_nx = (w_sa_nx[STAGES-1] == w_sb_nx[STAGES-1])
                && (w_sum_nx[STAGES-1][WIDTH-1] != w_sa_nx[STAGES-1]);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= '0;
            r_carry <= '0;
            r_sa    <= '0;
            r_sb    <= '0;
            r_ovf   <= 1'b0;
            // NOTE: the stage data arrays are cleared as well. Reset then leaves no stale operand anywhere.
            for (int k = 0; k < STAGES; k++) begin
                r_sum[k] <= '0;
                r_a[k]   <= '0;
                r_b[k]   <= '0;
            end
        end else begin
            // NOTE: sequential state uses non-blocking assignments. All stages then shift on the same edge.
            for (int k = 0; k < STAGES; k++) begin
                if (w_adv[k]) begin
                    r_valid[k] <= w_v_nx[k];
                    if (w_v_nx[k]) begin
                        r_sum[k]   <= w_sum_nx[k];
                        r_carry[k] <= w_c_nx[k];
                        r_a[k]     <= w_a_nx[k];
                        r_b[k]     <= w_b_nx[k];
                        r_sa[k]    <= w_sa_nx[k];
                        r_sb[k]    <= w_sb_nx[k];
                        if (k == STAGES - 1) r_ovf <= w_ovf_nx;
                    end
                end
            end
        end
    end

    assign bus.in_ready  = w_adv[0];
    assign bus.out_valid = r_valid[STAGES-1];
    assign bus.out       = r_sum[STAGES-1];
    assign bus.carry     = r_carry[STAGES-1];
    assign bus.overflow  = r_ovf;
endmodule

// File: tb/tb_adder_pipe.sv
// Scoreboard bench for adder_pipe. The directed tests run on a STAGES=2 instance.
// The STAGES=1 and STAGES=4 instances join in for full-rate random streaming.
module tb_adder_pipe;
    localparam int W = 32;

    typedef struct packed {
        logic [W-1:0] out;
        logic         carry;
        logic         ovf;
    } res_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic multi = 1'b0;
    always #5 clk = ~clk;

    int   checks   = 0;
    int   failures = 0;
    res_t q1[$], q2[$], q4[$];
    int   n_out1 = 0, n_out2 = 0, n_out4 = 0;

    adder_pipe_if #(.WIDTH(W)) bus1 ();
    adder_pipe_if #(.WIDTH(W)) bus2 ();
    adder_pipe_if #(.WIDTH(W)) bus4 ();

    assign bus1.in_valid  = bus2.in_valid && multi;
    assign bus1.in1       = bus2.in1;
    assign bus1.in2       = bus2.in2;
    assign bus1.sub       = bus2.sub;
    assign bus1.out_ready = 1'b1;
    assign bus4.in_valid  = bus2.in_valid && multi;
    assign bus4.in1       = bus2.in1;
    assign bus4.in2       = bus2.in2;
    assign bus4.sub       = bus2.sub;
    assign bus4.out_ready = 1'b1;

    adder_pipe #(.WIDTH(W), .STAGES(1)) u_dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1.slave));
    adder_pipe #(.WIDTH(W), .STAGES(2)) u_dut2 (.clk(clk), .rst_n(rst_n), .bus(bus2.slave));
    adder_pipe #(.WIDTH(W), .STAGES(4)) u_dut4 (.clk(clk), .rst_n(rst_n), .bus(bus4.slave));

    // Whole-word reference: B' = sub ? ~B : B, carry-in = sub.
    function automatic res_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
        logic [W-1:0] bb;
        logic [W:0]   t;
        res_t         r;
        bb      = s ? ~b : b;
        t       = {1'b0, a} + {1'b0, bb} + {{W{1'b0}}, s};
        r.out   = t[W-1:0];
        r.carry = t[W];
        r.ovf   = (a[W-1] == bb[W-1]) && (t[W-1] != a[W-1]);
        return r;
    endfunction

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // Monitors. Handshakes are sampled on the falling edge. A beat seen there transfers on the next rising edge.
    always @(negedge clk) if (rst_n) begin
        res_t e;
        if (bus1.in_valid && bus1.in_ready) q1.push_back(model(bus1.in1, bus1.in2, bus1.sub));
        if (bus1.out_valid && bus1.out_ready) begin
            n_out1++;
            check1("s1_expected_beat", q1.size() != 0, 1'b1);
            if (q1.size() != 0) begin
                e = q1.pop_front();
                check ("s1_out",      bus1.out,      e.out);
                check1("s1_carry",    bus1.carry,    e.carry);
                check1("s1_overflow", bus1.overflow, e.ovf);
            end
        end
    end

    always @(negedge clk) if (rst_n) begin
        res_t e;
        if (bus2.in_valid && bus2.in_ready) q2.push_back(model(bus2.in1, bus2.in2, bus2.sub));
        if (bus2.out_valid && bus2.out_ready) begin
            n_out2++;
            check1("s2_expected_beat", q2.size() != 0, 1'b1);
            if (q2.size() != 0) begin
                e = q2.pop_front();
                check ("s2_out",      bus2.out,      e.out);
                check1("s2_carry",    bus2.carry,    e.carry);
                check1("s2_overflow", bus2.overflow, e.ovf);
            end
        end
    end

    always @(negedge clk) if (rst_n) begin
        res_t e;
        if (bus4.in_valid && bus4.in_ready) q4.push_back(model(bus4.in1, bus4.in2, bus4.sub));
        if (bus4.out_valid && bus4.out_ready) begin
            n_out4++;
            check1("s4_expected_beat", q4.size() != 0, 1'b1);
            if (q4.size() != 0) begin
                e = q4.pop_front();
                check ("s4_out",      bus4.out,      e.out);
                check1("s4_carry",    bus4.carry,    e.carry);
                check1("s4_overflow", bus4.overflow, e.ovf);
            end
        end
    end

    // Offers one beat on the STAGES=2 port. Returns at posedge+1 after acceptance, or after a bounded wait.
    task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
        logic ok;
        ok = 1'b0;
        bus2.in1      = a;
        bus2.in2      = b;
        bus2.sub      = s;
        bus2.in_valid = 1'b1;
        for (int t = 0; t < 50 && !ok; t++) begin
            @(negedge clk);
            ok = bus2.in_ready;
            @(posedge clk);
            #1;
        end
        bus2.in_valid = 1'b0;
        check1("send_accepted", ok, 1'b1);
    endtask

    task automatic drain();
        for (int t = 0; t < 60 && (q1.size() + q2.size() + q4.size()) != 0; t++) begin
            @(posedge clk);
            #1;
        end
        check("drain_queues_empty", 32'(q1.size() + q2.size() + q4.size()), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: observed=running expected=finished");
        $fatal(1, "timeout");
    end

    initial begin
        int           base1, base2, base4, idx;
        logic [W-1:0] snap;
        snap          = '0;
        bus2.in_valid = 1'b0;
        bus2.in1      = '0;
        bus2.in2      = '0;
        bus2.sub      = 1'b0;
        bus2.out_ready = 1'b1;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check1("rst_out_valid", bus2.out_valid, 1'b0);
        check ("rst_out",       bus2.out,       0);
        check1("rst_carry",     bus2.carry,     1'b0);
        check1("rst_overflow",  bus2.overflow,  1'b0);
        check1("rst_in_ready",  bus2.in_ready,  1'b1);
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Basic add with latency: accepted at edge N, visible after edge N+1
        bus2.in1 = 32'h631; bus2.in2 = 32'd341; bus2.sub = 1'b0; bus2.in_valid = 1'b1;
        @(negedge clk);
        check1("basic_in_ready", bus2.in_ready, 1'b1);
        @(posedge clk);
        #1;
        bus2.in_valid = 1'b0;
        check1("latency_not_early", bus2.out_valid, 1'b0);
        @(posedge clk);
        #1;
        check1("latency_valid",  bus2.out_valid, 1'b1);
        check ("basic_out",      bus2.out,       32'd1926);
        check1("basic_carry",    bus2.carry,     1'b0);
        check1("basic_overflow", bus2.overflow,  1'b0);
        drain();

        send(32'o1461, 32'd0, 1'b0);
        @(posedge clk);
        #1;
        check("octal_out", bus2.out, 32'd817);

        // Wrap/carry, signed overflow, subtract with borrow
        send(32'hFFFF_FFFF, 32'd1, 1'b0);
        @(posedge clk);
        #1;
        check ("wrap_out",   bus2.out,   32'h0);
        check1("wrap_carry", bus2.carry, 1'b1);
        send(32'h7FFF_FFFF, 32'd1, 1'b0);
        @(posedge clk);
        #1;
        check ("posovf_out", bus2.out,      32'h8000_0000);
        check1("posovf_ovf", bus2.overflow, 1'b1);
        send(32'd5, 32'd7, 1'b1);
        @(posedge clk);
        #1;
        check ("borrow_out",   bus2.out,   32'hFFFF_FFFE);
        check1("borrow_carry", bus2.carry, 1'b0);
        send(32'h8000_0000, 32'd1, 1'b1);
        @(posedge clk);
        #1;
        check ("negovf_out", bus2.out,      32'h7FFF_FFFF);
        check1("negovf_ovf", bus2.overflow, 1'b1);
        drain();

        // Backpressure: stream i+i, hold out_ready low for cycles 3..7
        base2 = n_out2;
        idx   = 1;
        for (int cyc = 0; cyc < 40; cyc++) begin
            bus2.in_valid  = (idx <= 8);
            bus2.in1       = 32'(idx);
            bus2.in2       = 32'(idx);
            bus2.sub       = 1'b0;
            bus2.out_ready = !(cyc >= 3 && cyc < 8);
            @(negedge clk);
            if (cyc == 3) snap = bus2.out;
            if (cyc >= 3 && cyc < 8) begin
                check1("stall_in_ready",  bus2.in_ready,  1'b0);
                check1("stall_out_valid", bus2.out_valid, 1'b1);
                if (cyc > 3) check("stall_out_stable", bus2.out, snap);
            end
            if (bus2.in_valid && bus2.in_ready) idx++;
            @(posedge clk);
            #1;
        end
        bus2.in_valid  = 1'b0;
        bus2.out_ready = 1'b1;
        check("bp_delivered", 32'(n_out2 - base2), 8);
        check("bp_queue_empty", 32'(q2.size()), 0);

        // Full-rate random streaming on STAGES = 1, 2, 4
        multi = 1'b1;
        base1 = n_out1;
        base2 = n_out2;
        base4 = n_out4;
        for (int i = 0; i < 100; i++) begin
            bus2.in1      = $urandom;
            bus2.in2      = $urandom;
            bus2.sub      = 1'($urandom_range(0, 1));
            bus2.in_valid = 1'b1;
            @(negedge clk);
            check1("stream_in_ready_s1", bus1.in_ready, 1'b1);
            check1("stream_in_ready_s2", bus2.in_ready, 1'b1);
            check1("stream_in_ready_s4", bus4.in_ready, 1'b1);
            check1("stream_out_valid_s1", bus1.out_valid, i >= 1);
            check1("stream_out_valid_s2", bus2.out_valid, i >= 2);
            check1("stream_out_valid_s4", bus4.out_valid, i >= 4);
            @(posedge clk);
            #1;
        end
        bus2.in_valid = 1'b0;
        drain();
        multi = 1'b0;
        check("stream_count_s1", 32'(n_out1 - base1), 100);
        check("stream_count_s2", 32'(n_out2 - base2), 100);
        check("stream_count_s4", 32'(n_out4 - base4), 100);

        // Asynchronous reset with two beats in flight
        bus2.in1 = 32'h8000_0000; bus2.in2 = 32'h8000_0001; bus2.sub = 1'b0; bus2.in_valid = 1'b1;
        @(posedge clk);
        #1;
        bus2.in1 = 32'h7FFF_FFFF; bus2.in2 = 32'd1;
        @(posedge clk);
        #1;
        bus2.in_valid = 1'b0;
        check1("pre_rst_valid", bus2.out_valid, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        check1("midrst_out_valid", bus2.out_valid, 1'b0);
        check ("midrst_out",       bus2.out,       0);
        check1("midrst_carry",     bus2.carry,     1'b0);
        check1("midrst_overflow",  bus2.overflow,  1'b0);
        q1.delete();
        q2.delete();
        q4.delete();
        @(posedge clk);
        #3 rst_n = 1'b1;
        @(posedge clk);
        #1;
        check1("postrst_idle", bus2.out_valid, 1'b0);
        base2 = n_out2;
        send(32'd3, 32'd4, 1'b0);
        @(posedge clk);
        #1;
        check1("postrst_valid", bus2.out_valid, 1'b1);
        check ("postrst_out",   bus2.out,       32'd7);
        drain();
        repeat (3) @(posedge clk);
        #1;
        check("postrst_single_beat", 32'(n_out2 - base2), 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/adder_pipe.md
Name: adder_pipe

Overview:
Parametrised successor to the single-cycle registered 32-bit adder. A carry-segmented pipelined adder/subtractor with valid/ready handshakes on input and output, per-stage backpressure, and carry-out and signed-overflow flags. It sits between operand-producing logic and result consumers in datapaths that need a wide adder closing timing at high clock rates.

Parameters:
WIDTH, 32, operand and result width in bits; must be divisible by STAGES.
STAGES, 2, pipeline depth 1..4; each stage adds one WIDTH/STAGES-bit chunk, LSB chunk first.

Ports:
clk  input  1  clock; all state updates on rising edge.
rst_n  input  1  asynchronous, active-low reset.
in_valid  input  1  operand beat offered.
in_ready  output  1  adder accepts the beat this cycle.
in1  input  WIDTH  operand A.
in2  input  WIDTH  operand B.
sub  input  1  0: in1+in2; 1: in1-in2 (computed as in1 + ~in2 + 1).
out_valid  output  1  result beat offered.
out_ready  input  1  consumer accepts the result this cycle.
out  output  WIDTH  sum or difference, modulo 2^WIDTH.
carry  output  1  carry-out of the MSB chunk; in subtract mode 1 means no borrow.
overflow  output  1  two's-complement overflow of the operation.

Behaviour:
- Reset (rst_n low, asynchronous): all stage valid bits clear, out_valid=0, out=0, carry=0, overflow=0, and all internal data and carry registers clear. Reset mid-operation discards every in-flight beat. No beat is lost or duplicated after release.
- A beat transfers on the input when in_valid && in_ready at the clock edge. It transfers on the output when out_valid && out_ready.
- Stage k (0..STAGES-1) holds:
  - the partial result for chunks 0..k,
  - the carry into chunk k+1,
  - the unprocessed high chunks of A and ~B/B,
  - the MSB operand signs.
- Stage 0 adds chunk 0 with carry-in = sub. Stage k adds chunk k with the registered carry from stage k-1. The last stage drives out, carry and overflow directly from registers; there is no combinational path from in1/in2 to outputs.
- overflow = (signA == signB') && (signR != signA), where B' is the inverted B in subtract mode.
- Latency: a beat accepted at edge N appears with out_valid=1 after edge N+STAGES-1, i.e. it is visible in the cycle after N+STAGES-1, when the pipeline is not stalled.
- Throughput: one beat per cycle with out_ready held high.
- Stage k advances when its valid is 0 or stage k+1 advances. The last stage advances when !out_valid || out_ready. in_ready = stage-0 advance condition; this is a combinational ready chain and must not depend on in_valid.
- Bubbles collapse: an empty stage accepts from upstream even while downstream is stalled.
- Stall: while out_valid && !out_ready, out, carry and overflow hold stable. A full pipeline drops in_ready the same cycle.
- Simultaneous accept and drain on a full pipeline is legal and keeps one beat per cycle.
- Wrap-around: results wrap modulo 2^WIDTH. carry reports the lost bit.
- With STAGES=1 the block is one registered adder with a single-entry skid: in_ready = !out_valid || out_ready.
- in1/in2/sub are sampled only on accepted beats. Values on non-accepted cycles are ignored.

Test Plan:
- Basic add, WIDTH=32, STAGES=2: in1=0x631, in2=341, sub=0, out_ready=1 -> after 2 edges out=1926 (0x786), carry=0, overflow=0. Then in1=0o1461, in2=0 -> out=817.
- Wrap and carry: in1=0xFFFFFFFF, in2=1, sub=0 -> out=0, carry=1, overflow=0. in1=0x7FFFFFFF, in2=1 -> out=0x80000000, carry=0, overflow=1.
- Subtract and borrow: in1=5, in2=7, sub=1 -> out=0xFFFFFFFE, carry=0. in1=0x80000000, in2=1, sub=1 -> out=0x7FFFFFFF, overflow=1.
- Backpressure: stream operands i+i (i=1..8), hold out_ready=0 for 5 cycles mid-stream. Required:
  - in_ready falls once STAGES beats are held;
  - out stays stable while stalled;
  - all eight results (2..16) are delivered in order with none dropped or duplicated.
- Full-rate streaming: in_valid=1 and out_ready=1 continuously for 100 random beats with sub random, STAGES=1,2,4 -> one result per cycle, each matching the reference model including carry and overflow.
- Reset mid-operation: deassert rst_n asynchronously between edges with 2 beats in flight -> out_valid, out, carry and overflow go to 0 immediately. After release, the first new beat (3+4) yields out=7 with no stale beat emitted.
